// File: rtl/prea_deconv_expand.sv
// rtl/prea_deconv_expand.sv - Winograd deconvolution expansion, 4x4 tile in, 6x6 A*X*A^T out, row-serial
// Rows are buffered during LOAD; each output row is built from the buffered tile as it is emitted.
module prea_deconv_expand #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_row [4],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_row [6],
  output logic [2:0]               out_idx,
  output logic                     out_last
);

  typedef enum logic {LOAD, EMIT} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               r_q, r_d;
  logic [2:0]               idx_q, idx_d;
  logic                     last_q, last_d;
  logic signed [DATA_W-1:0] tile_q [4][4];
  logic signed [OUT_W-1:0]  row_q [6];
  logic signed [OUT_W-1:0]  row_d [6];
  logic signed [OUT_W-1:0]  t [4];
  logic signed [OUT_W-1:0]  exp_row [6];
  logic [2:0]               sel_k;
  logic                     load_row;
  logic                     wr_en;

  function automatic logic [OUT_W-1:0] sx(input logic [DATA_W-1:0] v);
    return {{(OUT_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  // Gather tile rows for A[sel_k] first, then scatter the columns through A^T.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      t[j] = '0;
      case (sel_k)
        3'd0:    t[j] = sx(tile_q[0][j]);
        3'd1:    t[j] = sx(tile_q[0][j]) + sx(tile_q[2][j]);
        3'd2:    t[j] = sx(tile_q[2][j]);
        3'd3:    t[j] = sx(tile_q[1][j]);
        3'd4:    t[j] = sx(tile_q[1][j]) + sx(tile_q[3][j]);
        3'd5:    t[j] = sx(tile_q[3][j]);
        default: t[j] = '0;
      endcase
    end
  end

  assign exp_row[0] = t[0];
  assign exp_row[1] = t[0] + t[2];
  assign exp_row[2] = t[2];
  assign exp_row[3] = t[1];
  assign exp_row[4] = t[1] + t[3];
  assign exp_row[5] = t[3];

  assign wr_en = (state_q == LOAD) && in_valid;

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    idx_d    = idx_q;
    last_d   = last_q;
    sel_k    = idx_q + 3'd1;
    load_row = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          r_d = r_q + 2'd1;
          // Row 0 only depends on X[0], already in the buffer by the 4th beat.
          if (r_q == 2'd3) begin
            state_d  = EMIT;
            sel_k    = 3'd0;
            load_row = 1'b1;
            idx_d    = 3'd0;
            last_d   = 1'b0;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q == 3'd5) begin
            state_d = LOAD;
            idx_d   = 3'd0;
            last_d  = 1'b0;
          end else begin
            idx_d    = idx_q + 3'd1;
            load_row = 1'b1;
            last_d   = (idx_q == 3'd4);
          end
        end
      end
      default: state_d = LOAD;
    endcase
    for (int l = 0; l < 6; l++) begin
      row_d[l] = load_row ? exp_row[l] : row_q[l];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      r_q     <= 2'd0;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      for (int l = 0; l < 6; l++) row_q[l] <= '0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) tile_q[i][j] <= '0;
      end
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      for (int l = 0; l < 6; l++) row_q[l] <= row_d[l];
      if (wr_en) begin
        for (int j = 0; j < 4; j++) tile_q[r_q][j] <= in_row[j];
      end
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == EMIT);
  assign out_row   = row_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_prea_deconv_expand.sv
// tb/tb_prea_deconv_expand.sv - self-checking bench for prea_deconv_expand against an A*X*A^T matrix model
module tb_prea_deconv_expand;

  localparam int DATA_W = 16;
  localparam int OUT_W  = DATA_W + 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_row [4];
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [OUT_W-1:0]  out_row [6];
  logic [2:0]               out_idx;
  logic                     out_last;

  int n_checks = 0;
  int n_fail   = 0;

  int amat [6][4] = '{'{1,0,0,0}, '{1,0,1,0}, '{0,0,1,0}, '{0,1,0,0}, '{0,1,0,1}, '{0,0,0,1}};
  int mx [4][4];
  int bx [3][4][4];

  prea_deconv_expand #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int model_y(input int k, input int l);
    int s = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        s += amat[k][i] * mx[i][j] * amat[l][j];
    return s;
  endfunction

  task automatic fill_tile(input int v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) mx[i][j] = v;
  endtask

  task automatic rand_tile();
    logic signed [DATA_W-1:0] v;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        v = DATA_W'($urandom);
        mx[i][j] = v;
      end
  endtask

  task automatic send_tile(input string name, input bit gaps);
    for (int r = 0; r < 4; r++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          for (int j = 0; j < 4; j++) in_row[j] = DATA_W'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      for (int j = 0; j < 4; j++) in_row[j] = DATA_W'(mx[r][j]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: out_valid=%b one cycle after 4th beat, expected 1", name, out_valid);
    end
  endtask

  task automatic drain(input string name, input int stop_at, input int stall_at);
    int guard;
    int got;
    int expv;
    for (int k = 0; k < 6; k++) begin
      guard = 0;
      while (out_valid !== 1'b1 && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL %s timeout waiting for row %0d: out_valid=%b expected 1", name, k, out_valid);
        return;
      end
      n_checks++;
      if (out_idx !== 3'(k)) begin
        n_fail++;
        $display("FAIL %s out_idx: got %0d expected %0d", name, out_idx, k);
      end
      n_checks++;
      if (out_last !== (k == 5)) begin
        n_fail++;
        $display("FAIL %s out_last row %0d: got %b expected %b", name, k, out_last, k == 5);
      end
      for (int l = 0; l < 6; l++) begin
        got  = out_row[l];
        expv = model_y(k, l);
        n_checks++;
        if (got !== expv) begin
          n_fail++;
          $display("FAIL %s Y[%0d][%0d]: got %0d expected %0d", name, k, l, got, expv);
        end
      end
      if (k == stop_at) return;
      if (k == stall_at) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
          for (int j = 0; j < 4; j++) in_row[j] = DATA_W'($urandom);
          @(negedge clk);
          n_checks++;
          if (out_idx !== 3'(k) || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s stall cycle %0d: idx=%0d valid=%b in_ready=%b expected idx=%0d valid=1 in_ready=0",
                     name, c, out_idx, out_valid, in_ready, k);
          end
          for (int l = 0; l < 6; l++) begin
            got  = out_row[l];
            expv = model_y(k, l);
            n_checks++;
            if (got !== expv) begin
              n_fail++;
              $display("FAIL %s stall Y[%0d][%0d]: got %0d expected %0d", name, k, l, got, expv);
            end
          end
        end
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s return to load: in_ready=%b out_valid=%b expected 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    int got;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: in_ready=%b out_valid=%b out_idx=%0d out_last=%b expected 1/0/0/0",
               in_ready, out_valid, out_idx, out_last);
    end
    for (int l = 0; l < 6; l++) begin
      got = out_row[l];
      n_checks++;
      if (got !== 0) begin
        n_fail++;
        $display("FAIL reset out_row[%0d]: got %0d expected 0", l, got);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_impulse();
    fill_tile(0);
    mx[0][0] = 1;
    send_tile("impulse", 1'b0);
    drain("impulse", 6, -1);
  endtask

  task automatic test_all_ones();
    fill_tile(1);
    send_tile("all_ones", 1'b1);
    drain("all_ones", 6, -1);
  endtask

  task automatic test_extremes();
    fill_tile(-32768);
    send_tile("min", 1'b0);
    drain("min", 6, -1);
    fill_tile(32767);
    send_tile("max", 1'b0);
    drain("max", 6, -1);
  endtask

  task automatic test_backpressure();
    rand_tile();
    send_tile("stall", 1'b1);
    drain("stall", 6, 2);
    rand_tile();
    send_tile("after_stall", 1'b0);
    drain("after_stall", 6, -1);
  endtask

  task automatic test_reset_mid();
    rand_tile();
    send_tile("rst_emit", 1'b0);
    drain("rst_emit", 3, -1);
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_emit async: out_valid=%b in_ready=%b out_idx=%0d expected 0/1/0",
               out_valid, in_ready, out_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) in_row[j] = DATA_W'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rand_tile();
    send_tile("rst_fresh", 1'b1);
    drain("rst_fresh", 6, -1);
  endtask

  task automatic test_back_to_back();
    int t_in = 0, r_in = 0, t_out = 0, k_out = 0, lasts = 0;
    int got, expv;
    for (int t = 0; t < 3; t++) begin
      rand_tile();
      bx[t] = mx;
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid === 1'b1 && t_out < 3) begin
        mx = bx[t_out];
        n_checks++;
        if (out_idx !== 3'(k_out) || out_last !== (k_out == 5)) begin
          n_fail++;
          $display("FAIL b2b tile %0d idx/last: got %0d/%b expected %0d/%b",
                   t_out, out_idx, out_last, k_out, k_out == 5);
        end
        for (int l = 0; l < 6; l++) begin
          got  = out_row[l];
          expv = model_y(k_out, l);
          n_checks++;
          if (got !== expv) begin
            n_fail++;
            $display("FAIL b2b tile %0d Y[%0d][%0d]: got %0d expected %0d", t_out, k_out, l, got, expv);
          end
        end
        if (out_last === 1'b1) lasts++;
        k_out++;
        if (k_out == 6) begin
          k_out = 0;
          t_out++;
        end
      end
      if (in_ready === 1'b1 && t_in < 3) begin
        for (int j = 0; j < 4; j++) in_row[j] = DATA_W'(bx[t_in][r_in][j]);
        r_in++;
        if (r_in == 4) begin
          r_in = 0;
          t_in++;
        end
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (t_out !== 3 || lasts !== 3) begin
      n_fail++;
      $display("FAIL b2b throughput: tiles out=%0d last pulses=%0d in 30 cycles, expected 3/3", t_out, lasts);
    end
  endtask

  initial begin
    for (int j = 0; j < 4; j++) in_row[j] = '0;
    test_reset();
    test_impulse();
    test_all_ones();
    test_extremes();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
